// File: rtl/gvizi_delay_core.sv
// gvizi_delay_core: N-channel delay-pulse generator (GZI charge/discharge, GVI pulse).
// Optional burst repeat is enabled by defining GVIZI_BURST_EN.
module gvizi_delay_core #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int PRESC_W  = 8,
    parameter int FC_TICKS = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_cfg_we,
    input  logic [7:0]        i_cfg_addr,
    input  logic [CNT_W-1:0]  i_cfg_wdata,
    input  logic [N_CH-1:0]   i_fb,
    output logic [N_CH-1:0]   o_charge,
    output logic [N_CH-1:0]   o_discharge,
    output logic [N_CH-1:0]   o_out,
    output logic              o_first_charge,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic              o_fb_timeout
);

    localparam int FC_W = (FC_TICKS > 1) ? $clog2(FC_TICKS) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FC_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FCHG,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;

    logic [1:0]          r_sync;
    logic                r_start_d;
    logic                w_edge;

    logic                r_sh_mode;
    logic [N_CH-1:0]     r_sh_en;
    logic [PRESC_W-1:0]  r_sh_p;
    logic [CNT_W-1:0]    r_sh_w;
    logic [CNT_W-1:0]    r_sh_d [N_CH];

    logic                r_mode;
    logic [N_CH-1:0]     r_en;
    logic [PRESC_W-1:0]  r_p;
    logic [CNT_W-1:0]    r_w;
    logic [CNT_W-1:0]    r_d [N_CH];

    logic [PRESC_W-1:0]  r_presc;
    logic [FC_W-1:0]     r_fc;
    logic [CNT_W-1:0]    r_cnt [N_CH];
    logic [CNT_W-1:0]    r_wc [N_CH];
    logic [N_CH-1:0]     r_fbc;
    logic [N_CH-1:0]     r_fired;
    logic [N_CH-1:0]     r_cmp;

`ifdef GVIZI_BURST_EN
    logic [CNT_W-9:0]    r_sh_b;
    logic [CNT_W-9:0]    r_b;
    logic [CNT_W-9:0]    r_bcnt;
`endif

    logic                w_tick;
    logic                w_ctrl_wr;

    assign w_edge    = r_sync[1] & ~r_start_d;
    assign w_tick    = (r_presc == r_p);
    assign w_ctrl_wr = i_cfg_we && (i_cfg_addr == 8'd0);

    // Bring the asynchronous start into the clock domain and find its rising edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b00;
            r_start_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_start};
            r_start_d <= r_sync[1];
        end
    end

    // Shadow configuration registers, writable at any time.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_mode <= 1'b0;
            r_sh_en   <= '0;
            r_sh_p    <= '0;
            r_sh_w    <= CNT_W'(1);
            for (int k = 0; k < N_CH; k++) r_sh_d[k] <= '0;
`ifdef GVIZI_BURST_EN
            r_sh_b    <= '0;
`endif
        end else if (i_cfg_we) begin
            if (i_cfg_addr == 8'd0) begin
                r_sh_mode <= i_cfg_wdata[0];
                r_sh_en   <= i_cfg_wdata[N_CH+1:2];
`ifdef GVIZI_BURST_EN
                r_sh_b    <= i_cfg_wdata[CNT_W-1:8];
`endif
            end
            if (i_cfg_addr == 8'd1) r_sh_p <= PRESC_W'(i_cfg_wdata);
            if (i_cfg_addr == 8'd2) r_sh_w <= i_cfg_wdata;
            for (int k = 0; k < N_CH; k++) begin
                if (i_cfg_addr == 8'(k + 3)) r_sh_d[k] <= i_cfg_wdata;
            end
        end
    end

    // Sequencer: prescaler, phase FSM, per-channel timing and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_en           <= '0;
            r_p            <= '0;
            r_w            <= CNT_W'(1);
            r_presc        <= '0;
            r_fc           <= '0;
            r_fbc          <= '0;
            r_fired        <= '0;
            r_cmp          <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_d[k]   <= '0;
                r_cnt[k] <= '0;
                r_wc[k]  <= '0;
            end
`ifdef GVIZI_BURST_EN
            r_b            <= '0;
            r_bcnt         <= '0;
`endif
            o_charge       <= '0;
            o_discharge    <= '0;
            o_out          <= '0;
            o_first_charge <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_overrun      <= 1'b0;
            o_fb_timeout   <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                o_overrun    <= 1'b0;
                o_fb_timeout <= 1'b0;
            end
            if (w_edge && (r_state != S_IDLE)) o_overrun <= 1'b1;

            if (w_tick) r_presc <= '0;
            else        r_presc <= r_presc + 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    if (w_edge && (r_sh_en != '0)) begin
                        r_mode         <= r_sh_mode;
                        r_en           <= r_sh_en;
                        r_p            <= r_sh_p;
                        r_w            <= (r_sh_w == '0) ? CNT_W'(1) : r_sh_w;
                        for (int k = 0; k < N_CH; k++) r_d[k] <= r_sh_d[k];
`ifdef GVIZI_BURST_EN
                        r_b            <= r_sh_b;
                        r_bcnt         <= '0;
`endif
                        r_presc        <= '0;
                        r_fc           <= '0;
                        r_state        <= S_FCHG;
                        o_first_charge <= 1'b1;
                        o_busy         <= 1'b1;
                        o_charge       <= r_sh_mode ? '0 : r_sh_en;
                    end
                end
                S_FCHG: begin
                    if (w_tick) begin
                        if (r_fc == FC_LAST) begin
                            r_state        <= S_RUN;
                            o_first_charge <= 1'b0;
                            r_cmp          <= ~r_en;
                            r_fired        <= '0;
                            for (int k = 0; k < N_CH; k++) r_cnt[k] <= r_d[k];
                        end else begin
                            r_fc <= r_fc + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (&r_cmp) begin
`ifdef GVIZI_BURST_EN
                        if (r_bcnt != r_b) begin
                            r_bcnt         <= r_bcnt + 1'b1;
                            r_presc        <= '0;
                            r_fc           <= '0;
                            r_state        <= S_FCHG;
                            o_first_charge <= 1'b1;
                            o_charge       <= r_mode ? '0 : r_en;
                        end else
`endif
                        begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end
                    end else begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (!r_cmp[k]) begin
                                if (!r_fired[k]) begin
                                    if (w_tick) begin
                                        if (r_cnt[k] == '0) begin
                                            r_fired[k] <= 1'b1;
                                            r_wc[k]    <= r_w;
                                            r_fbc[k]   <= 1'b0;
                                            if (r_mode) begin
                                                o_out[k] <= 1'b1;
                                            end else begin
                                                o_charge[k]    <= 1'b0;
                                                o_discharge[k] <= 1'b1;
                                            end
                                        end else begin
                                            r_cnt[k] <= r_cnt[k] - 1'b1;
                                        end
                                    end
                                end else if (r_mode) begin
                                    if (w_tick) begin
                                        if (r_wc[k] == CNT_W'(1)) begin
                                            o_out[k] <= 1'b0;
                                            r_cmp[k] <= 1'b1;
                                        end else begin
                                            r_wc[k] <= r_wc[k] - 1'b1;
                                        end
                                    end
                                end else begin
                                    if (!i_fb[k] && r_fbc[k]) begin
                                        o_discharge[k] <= 1'b0;
                                        r_cmp[k]       <= 1'b1;
                                    end else if (w_tick && (r_wc[k] == CNT_W'(1))) begin
                                        o_discharge[k] <= 1'b0;
                                        r_cmp[k]       <= 1'b1;
                                        o_fb_timeout   <= 1'b1;
                                    end else begin
                                        r_fbc[k] <= ~i_fb[k];
                                        if (w_tick) r_wc[k] <= r_wc[k] - 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
